// File: rtl/reservation_station_pkg.sv
// Shared constants and types for the reservation station and its neighbours
// (dispatcher, RoB, LSB) in the Tomasulo core.
package reservation_station_pkg;

  localparam int RS_WIDTH     = 3;
  localparam int RS_SIZE      = 1 << RS_WIDTH;
  localparam int RoB_WIDTH    = 4;
  localparam int EX_RoB_WIDTH = RoB_WIDTH + 1;
  localparam int ADDR_WIDTH   = 32;
  localparam int REG_WIDTH    = 32;
  localparam int OPCODE_WIDTH = 7;

  // Tag value whose extra top bit marks the operand value as already valid.
  localparam logic [EX_RoB_WIDTH-1:0] NON_DEP = EX_RoB_WIDTH'(1 << RoB_WIDTH);

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_LUI   = 7'd1,  OP_AUIPC = 7'd2,  OP_JAL   = 7'd3,  OP_JALR  = 7'd4,
    OP_BEQ   = 7'd5,  OP_BNE   = 7'd6,  OP_BLT   = 7'd7,  OP_BGE   = 7'd8,
    OP_BLTU  = 7'd9,  OP_BGEU  = 7'd10, OP_LB    = 7'd11, OP_LH    = 7'd12,
    OP_LW    = 7'd13, OP_LBU   = 7'd14, OP_LHU   = 7'd15, OP_SB    = 7'd16,
    OP_SH    = 7'd17, OP_SW    = 7'd18, OP_ADDI  = 7'd19, OP_SLTI  = 7'd20,
    OP_SLTIU = 7'd21, OP_XORI  = 7'd22, OP_ORI   = 7'd23, OP_ANDI  = 7'd24,
    OP_SLLI  = 7'd25, OP_SRLI  = 7'd26, OP_SRAI  = 7'd27, OP_ADD   = 7'd28,
    OP_SUB   = 7'd29, OP_SLL   = 7'd30, OP_SLT   = 7'd31, OP_SLTU  = 7'd32,
    OP_XORR  = 7'd33, OP_SRL   = 7'd34, OP_SRA   = 7'd35, OP_ORR   = 7'd36,
    OP_ANDD  = 7'd37
  } opcode_e;

  typedef struct packed {
    logic [EX_RoB_WIDTH-1:0] tag;
    logic [REG_WIDTH-1:0]    value;
  } operand_t;

  typedef struct packed {
    logic                    busy;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [ADDR_WIDTH-1:0]   pc;
    operand_t                j;
    operand_t                k;
    logic [REG_WIDTH-1:0]    imm;
    logic [RoB_WIDTH-1:0]    robIdx;
  } rs_entry_t;

  // RS channel wins if both broadcasts could match; in practice they never do.
  function automatic operand_t resolveOperand(
    input operand_t               op,
    input logic                   rsEn,
    input logic [RoB_WIDTH-1:0]   rsIdx,
    input logic [REG_WIDTH-1:0]   rsValue,
    input logic                   lsbEn,
    input logic [RoB_WIDTH-1:0]   lsbIdx,
    input logic [REG_WIDTH-1:0]   lsbValue
  );
    operand_t res;
    res = op;
    if (op.tag != NON_DEP) begin
      if (rsEn && (op.tag == {1'b0, rsIdx})) begin
        res.tag   = NON_DEP;
        res.value = rsValue;
      end else if (lsbEn && (op.tag == {1'b0, lsbIdx})) begin
        res.tag   = NON_DEP;
        res.value = lsbValue;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Dispatcher, CDB, RoB and ALU signals seen by the reservation station.
interface reservation_station_if;
  import reservation_station_pkg::*;

  logic                    DPRS_en;
  logic [ADDR_WIDTH-1:0]   DPRS_pc;
  logic [EX_RoB_WIDTH-1:0] DPRS_Qj;
  logic [EX_RoB_WIDTH-1:0] DPRS_Qk;
  logic [REG_WIDTH-1:0]    DPRS_Vj;
  logic [REG_WIDTH-1:0]    DPRS_Vk;
  logic [REG_WIDTH-1:0]    DPRS_imm;
  logic [OPCODE_WIDTH-1:0] DPRS_opcode;
  logic [RoB_WIDTH-1:0]    DPRS_RoB_index;
  logic                    RSDP_full;

  logic                    RoBRS_pre_judge;

  logic                    CDBRS_RS_en;
  logic [RoB_WIDTH-1:0]    CDBRS_RS_RoB_index;
  logic [REG_WIDTH-1:0]    CDBRS_RS_value;
  logic                    CDBRS_LSB_en;
  logic [RoB_WIDTH-1:0]    CDBRS_LSB_RoB_index;
  logic [REG_WIDTH-1:0]    CDBRS_LSB_value;

  logic                    RSALU_en;
  logic [OPCODE_WIDTH-1:0] RSALU_opcode;
  logic [ADDR_WIDTH-1:0]   RSALU_pc;
  logic [REG_WIDTH-1:0]    RSALU_Vj;
  logic [REG_WIDTH-1:0]    RSALU_Vk;
  logic [REG_WIDTH-1:0]    RSALU_imm;
  logic [RoB_WIDTH-1:0]    RSALU_RoB_index;

  modport master (
    output DPRS_en, DPRS_pc, DPRS_Qj, DPRS_Qk, DPRS_Vj, DPRS_Vk, DPRS_imm,
           DPRS_opcode, DPRS_RoB_index, RoBRS_pre_judge,
           CDBRS_RS_en, CDBRS_RS_RoB_index, CDBRS_RS_value,
           CDBRS_LSB_en, CDBRS_LSB_RoB_index, CDBRS_LSB_value,
    input  RSDP_full, RSALU_en, RSALU_opcode, RSALU_pc, RSALU_Vj, RSALU_Vk,
           RSALU_imm, RSALU_RoB_index
  );

  modport slave (
    input  DPRS_en, DPRS_pc, DPRS_Qj, DPRS_Qk, DPRS_Vj, DPRS_Vk, DPRS_imm,
           DPRS_opcode, DPRS_RoB_index, RoBRS_pre_judge,
           CDBRS_RS_en, CDBRS_RS_RoB_index, CDBRS_RS_value,
           CDBRS_LSB_en, CDBRS_LSB_RoB_index, CDBRS_LSB_value,
    output RSDP_full, RSALU_en, RSALU_opcode, RSALU_pc, RSALU_Vj, RSALU_Vk,
           RSALU_imm, RSALU_RoB_index
  );

endinterface

// File: rtl/rs_priority_enc.sv
// Lowest-set-bit encoder: returns the index of the lowest asserted request
// and a flag telling whether any request was asserted at all.
module rs_priority_enc #(
  parameter int WIDTH     = 8,
  parameter int IDX_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]     req_i,
  output logic                 found_o,
  output logic [IDX_WIDTH-1:0] idx_o
);

  // Scanning downward lets the lowest index overwrite any higher hit.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        found_o = 1'b1;
        idx_o   = IDX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: buffers non-memory instructions until both operands are
// resolved from the CDB, then issues the lowest-index ready entry to the ALU.
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic                 Sys_clk,
  input  logic                 Sys_rst,
  input  logic                 Sys_rdy,
  reservation_station_if.slave rsBus
);

  rs_entry_t               entries_q [RS_SIZE];
  rs_entry_t               entries_d [RS_SIZE];
  logic [RS_SIZE-1:0]      busyVec;
  logic [RS_SIZE-1:0]      readyVec;
  logic                    freeFound;
  logic                    issueFound;
  logic [RS_WIDTH-1:0]     freeIdx;
  logic [RS_WIDTH-1:0]     issueIdx;
  logic                    clearAll;
  operand_t                inJ;
  operand_t                inK;

  logic                    aluEn_q,     aluEn_d;
  logic [OPCODE_WIDTH-1:0] aluOpcode_q, aluOpcode_d;
  logic [ADDR_WIDTH-1:0]   aluPc_q,     aluPc_d;
  logic [REG_WIDTH-1:0]    aluVj_q,     aluVj_d;
  logic [REG_WIDTH-1:0]    aluVk_q,     aluVk_d;
  logic [REG_WIDTH-1:0]    aluImm_q,    aluImm_d;
  logic [RoB_WIDTH-1:0]    aluRobIdx_q, aluRobIdx_d;

  always_comb begin
    busyVec  = '0;
    readyVec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      busyVec[i]  = entries_q[i].busy;
      readyVec[i] = entries_q[i].busy && (entries_q[i].j.tag == NON_DEP)
                    && (entries_q[i].k.tag == NON_DEP);
    end
  end

  rs_priority_enc #(.WIDTH(RS_SIZE), .IDX_WIDTH(RS_WIDTH)) freeEnc (
    .req_i   (~busyVec),
    .found_o (freeFound),
    .idx_o   (freeIdx)
  );

  rs_priority_enc #(.WIDTH(RS_SIZE), .IDX_WIDTH(RS_WIDTH)) issueEnc (
    .req_i   (readyVec),
    .found_o (issueFound),
    .idx_o   (issueIdx)
  );

  // The one-free case asserts full early so the dispatcher sees the in-flight write.
  assign rsBus.RSDP_full = (&busyVec) | ($onehot(~busyVec) & rsBus.DPRS_en);

  assign clearAll = Sys_rst | (Sys_rdy & ~rsBus.RoBRS_pre_judge);
  assign inJ      = '{tag: rsBus.DPRS_Qj, value: rsBus.DPRS_Vj};
  assign inK      = '{tag: rsBus.DPRS_Qk, value: rsBus.DPRS_Vk};

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      entries_d[i] = entries_q[i];
      if (entries_q[i].busy) begin
        entries_d[i].j = resolveOperand(entries_q[i].j,
                           rsBus.CDBRS_RS_en,  rsBus.CDBRS_RS_RoB_index,  rsBus.CDBRS_RS_value,
                           rsBus.CDBRS_LSB_en, rsBus.CDBRS_LSB_RoB_index, rsBus.CDBRS_LSB_value);
        entries_d[i].k = resolveOperand(entries_q[i].k,
                           rsBus.CDBRS_RS_en,  rsBus.CDBRS_RS_RoB_index,  rsBus.CDBRS_RS_value,
                           rsBus.CDBRS_LSB_en, rsBus.CDBRS_LSB_RoB_index, rsBus.CDBRS_LSB_value);
      end
    end

    aluEn_d     = 1'b0;
    aluOpcode_d = aluOpcode_q;
    aluPc_d     = aluPc_q;
    aluVj_d     = aluVj_q;
    aluVk_d     = aluVk_q;
    aluImm_d    = aluImm_q;
    aluRobIdx_d = aluRobIdx_q;

    if (issueFound) begin
      aluEn_d                  = 1'b1;
      aluOpcode_d              = entries_q[issueIdx].opcode;
      aluPc_d                  = entries_q[issueIdx].pc;
      aluVj_d                  = entries_q[issueIdx].j.value;
      aluVk_d                  = entries_q[issueIdx].k.value;
      aluImm_d                 = entries_q[issueIdx].imm;
      aluRobIdx_d              = entries_q[issueIdx].robIdx;
      entries_d[issueIdx].busy = 1'b0;
    end

    // A free slot is never busy, so it can never collide with the issuing entry.
    if (rsBus.DPRS_en && freeFound) begin
      entries_d[freeIdx].busy   = 1'b1;
      entries_d[freeIdx].opcode = rsBus.DPRS_opcode;
      entries_d[freeIdx].pc     = rsBus.DPRS_pc;
      entries_d[freeIdx].imm    = rsBus.DPRS_imm;
      entries_d[freeIdx].robIdx = rsBus.DPRS_RoB_index;
      entries_d[freeIdx].j      = resolveOperand(inJ,
                                    rsBus.CDBRS_RS_en,  rsBus.CDBRS_RS_RoB_index,  rsBus.CDBRS_RS_value,
                                    rsBus.CDBRS_LSB_en, rsBus.CDBRS_LSB_RoB_index, rsBus.CDBRS_LSB_value);
      entries_d[freeIdx].k      = resolveOperand(inK,
                                    rsBus.CDBRS_RS_en,  rsBus.CDBRS_RS_RoB_index,  rsBus.CDBRS_RS_value,
                                    rsBus.CDBRS_LSB_en, rsBus.CDBRS_LSB_RoB_index, rsBus.CDBRS_LSB_value);
    end
  end

  always_ff @(posedge Sys_clk) begin
    if (clearAll) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entries_q[i] <= '0;
      end
      aluEn_q     <= 1'b0;
      aluOpcode_q <= '0;
      aluPc_q     <= '0;
      aluVj_q     <= '0;
      aluVk_q     <= '0;
      aluImm_q    <= '0;
      aluRobIdx_q <= '0;
    end else if (Sys_rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entries_q[i] <= entries_d[i];
      end
      aluEn_q     <= aluEn_d;
      aluOpcode_q <= aluOpcode_d;
      aluPc_q     <= aluPc_d;
      aluVj_q     <= aluVj_d;
      aluVk_q     <= aluVk_d;
      aluImm_q    <= aluImm_d;
      aluRobIdx_q <= aluRobIdx_d;
    end
  end

  assign rsBus.RSALU_en        = aluEn_q;
  assign rsBus.RSALU_opcode    = aluOpcode_q;
  assign rsBus.RSALU_pc        = aluPc_q;
  assign rsBus.RSALU_Vj        = aluVj_q;
  assign rsBus.RSALU_Vk        = aluVk_q;
  assign rsBus.RSALU_imm       = aluImm_q;
  assign rsBus.RSALU_RoB_index = aluRobIdx_q;

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for the reservation station: directed scenarios plus a
// randomized run compared against an array-based model of the station.
module tb_reservation_station;
  import reservation_station_pkg::*;

  localparam int READY_TAG = 16;
  localparam int SLOTS     = 8;

  logic Sys_clk = 1'b0;
  logic Sys_rst;
  logic Sys_rdy;

  reservation_station_if rsIf();

  reservation_station dut (
    .Sys_clk (Sys_clk),
    .Sys_rst (Sys_rst),
    .Sys_rdy (Sys_rdy),
    .rsBus   (rsIf)
  );

  always #5 Sys_clk = ~Sys_clk;

  int testsRun    = 0;
  int testsFailed = 0;

  // Behavioural model: one slot per array element, tags as plain integers.
  bit          mBusy   [SLOTS];
  logic [6:0]  mOpcode [SLOTS];
  logic [31:0] mPc     [SLOTS];
  int          mQj     [SLOTS];
  int          mQk     [SLOTS];
  logic [31:0] mVj     [SLOTS];
  logic [31:0] mVk     [SLOTS];
  logic [31:0] mImm    [SLOTS];
  logic [3:0]  mRob    [SLOTS];
  logic        eEn;
  logic [6:0]  eOpcode;
  logic [31:0] ePc, eVj, eVk, eImm;
  logic [3:0]  eRob;

  function automatic int mFreeCount();
    int n = 0;
    for (int i = 0; i < SLOTS; i++) if (!mBusy[i]) n++;
    return n;
  endfunction

  function automatic void wakeOperand(inout int tag, inout logic [31:0] value);
    if (tag == READY_TAG) return;
    if (rsIf.CDBRS_RS_en && tag == int'(rsIf.CDBRS_RS_RoB_index)) begin
      value = rsIf.CDBRS_RS_value;
      tag   = READY_TAG;
    end else if (rsIf.CDBRS_LSB_en && tag == int'(rsIf.CDBRS_LSB_RoB_index)) begin
      value = rsIf.CDBRS_LSB_value;
      tag   = READY_TAG;
    end
  endfunction

  task automatic modelClear();
    for (int i = 0; i < SLOTS; i++) mBusy[i] = 1'b0;
    eEn = 1'b0; eOpcode = '0; ePc = '0; eVj = '0; eVk = '0; eImm = '0; eRob = '0;
  endtask

  task automatic modelEdge();
    int issueSel = -1;
    int freeSel  = -1;
    int q;
    logic [31:0] v;
    if (Sys_rst || (Sys_rdy && !rsIf.RoBRS_pre_judge)) begin
      modelClear();
      return;
    end
    if (!Sys_rdy) return;
    for (int i = 0; i < SLOTS; i++) begin
      if (issueSel < 0 && mBusy[i] && mQj[i] == READY_TAG && mQk[i] == READY_TAG) issueSel = i;
      if (freeSel < 0 && !mBusy[i]) freeSel = i;
    end
    for (int i = 0; i < SLOTS; i++) begin
      if (mBusy[i]) begin
        q = mQj[i]; v = mVj[i]; wakeOperand(q, v); mQj[i] = q; mVj[i] = v;
        q = mQk[i]; v = mVk[i]; wakeOperand(q, v); mQk[i] = q; mVk[i] = v;
      end
    end
    eEn = 1'b0;
    if (issueSel >= 0) begin
      eEn = 1'b1; eOpcode = mOpcode[issueSel]; ePc = mPc[issueSel];
      eVj = mVj[issueSel]; eVk = mVk[issueSel]; eImm = mImm[issueSel]; eRob = mRob[issueSel];
      mBusy[issueSel] = 1'b0;
    end
    if (rsIf.DPRS_en && freeSel >= 0) begin
      mBusy[freeSel] = 1'b1; mOpcode[freeSel] = rsIf.DPRS_opcode; mPc[freeSel] = rsIf.DPRS_pc;
      mImm[freeSel] = rsIf.DPRS_imm; mRob[freeSel] = rsIf.DPRS_RoB_index;
      q = int'(rsIf.DPRS_Qj); v = rsIf.DPRS_Vj; wakeOperand(q, v); mQj[freeSel] = q; mVj[freeSel] = v;
      q = int'(rsIf.DPRS_Qk); v = rsIf.DPRS_Vk; wakeOperand(q, v); mQk[freeSel] = q; mVk[freeSel] = v;
    end
  endtask

  // Advance one clock; inputs stay stable across the edge, outputs are sampled 1 time unit later.
  task automatic step();
    assert (!(rsIf.DPRS_en && Sys_rdy && !Sys_rst && mFreeCount() == 0)) else begin
      testsFailed++;
      $display("[TB] FAIL protocol: DPRS_en=1 with %0d free entries, required at least 1", mFreeCount());
    end
    @(posedge Sys_clk);
    modelEdge();
    #1;
  endtask

  task automatic idle();
    Sys_rst = 1'b0; Sys_rdy = 1'b1;
    rsIf.RoBRS_pre_judge = 1'b1;
    rsIf.DPRS_en = 1'b0; rsIf.DPRS_pc = '0; rsIf.DPRS_Qj = 5'd16; rsIf.DPRS_Qk = 5'd16;
    rsIf.DPRS_Vj = '0; rsIf.DPRS_Vk = '0; rsIf.DPRS_imm = '0; rsIf.DPRS_opcode = '0;
    rsIf.DPRS_RoB_index = '0;
    rsIf.CDBRS_RS_en = 1'b0; rsIf.CDBRS_RS_RoB_index = '0; rsIf.CDBRS_RS_value = '0;
    rsIf.CDBRS_LSB_en = 1'b0; rsIf.CDBRS_LSB_RoB_index = '0; rsIf.CDBRS_LSB_value = '0;
  endtask

  task automatic setDispatch(input logic [6:0] op, input int qj, input logic [31:0] vj,
                             input int qk, input logic [31:0] vk, input int rob);
    rsIf.DPRS_en = 1'b1; rsIf.DPRS_opcode = op;
    rsIf.DPRS_pc = 32'h1000 + 32'(rob * 4); rsIf.DPRS_imm = 32'(rob);
    rsIf.DPRS_Qj = 5'(qj); rsIf.DPRS_Vj = vj; rsIf.DPRS_Qk = 5'(qk); rsIf.DPRS_Vk = vk;
    rsIf.DPRS_RoB_index = 4'(rob);
  endtask

  task automatic test_reset();
    idle(); Sys_rst = 1'b1;
    step(); step();
    Sys_rst = 1'b0; #1;
    testsRun++;
    if (rsIf.RSDP_full !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_full: got %b, expected 0", rsIf.RSDP_full); end
    testsRun++;
    if (rsIf.RSALU_en !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_en: got %b, expected 0", rsIf.RSALU_en); end
    testsRun++;
    if (rsIf.RSALU_RoB_index !== 4'd0) begin testsFailed++; $display("[TB] FAIL reset_rob: got %0d, expected 0", rsIf.RSALU_RoB_index); end
  endtask

  task automatic test_ready_dispatch();
    setDispatch(OP_ADD, 16, 32'd5, 16, 32'd7, 3); #1;
    testsRun++;
    if (rsIf.RSDP_full !== 1'b0) begin testsFailed++; $display("[TB] FAIL ready_full: got %b, expected 0", rsIf.RSDP_full); end
    step(); idle();
    testsRun++;
    if (rsIf.RSALU_en !== 1'b0) begin testsFailed++; $display("[TB] FAIL ready_early: got %b, expected 0", rsIf.RSALU_en); end
    step();
    testsRun++;
    if ({rsIf.RSALU_en, rsIf.RSALU_opcode, rsIf.RSALU_Vj, rsIf.RSALU_Vk, rsIf.RSALU_RoB_index, rsIf.RSALU_pc, rsIf.RSALU_imm}
        !== {1'b1, 7'd28, 32'd5, 32'd7, 4'd3, 32'h100C, 32'd3}) begin
      testsFailed++;
      $display("[TB] FAIL ready_issue: got en=%b op=%0d Vj=%0d Vk=%0d rob=%0d pc=%h imm=%0d, expected 1/28/5/7/3/100c/3",
               rsIf.RSALU_en, rsIf.RSALU_opcode, rsIf.RSALU_Vj, rsIf.RSALU_Vk, rsIf.RSALU_RoB_index, rsIf.RSALU_pc, rsIf.RSALU_imm);
    end
    step();
    testsRun++;
    if (rsIf.RSALU_en !== 1'b0) begin testsFailed++; $display("[TB] FAIL ready_after: got %b, expected 0", rsIf.RSALU_en); end
  endtask

  task automatic test_cdb_wakeup();
    setDispatch(OP_SUB, 2, 32'h1234, 16, 32'd1, 5);
    for (int c = 0; c < 3; c++) begin
      step(); idle();
      testsRun++;
      if (rsIf.RSALU_en !== 1'b0) begin testsFailed++; $display("[TB] FAIL wake_wait%0d: got %b, expected 0", c, rsIf.RSALU_en); end
    end
    rsIf.CDBRS_RS_en = 1'b1; rsIf.CDBRS_RS_RoB_index = 4'd2; rsIf.CDBRS_RS_value = 32'h55;
    step(); idle();
    testsRun++;
    if (rsIf.RSALU_en !== 1'b0) begin testsFailed++; $display("[TB] FAIL wake_cdb_cycle: got %b, expected 0", rsIf.RSALU_en); end
    step();
    testsRun++;
    if ({rsIf.RSALU_en, rsIf.RSALU_Vj, rsIf.RSALU_Vk, rsIf.RSALU_RoB_index} !== {1'b1, 32'h55, 32'd1, 4'd5}) begin
      testsFailed++;
      $display("[TB] FAIL wake_issue: got en=%b Vj=%h Vk=%h rob=%0d, expected 1/55/1/5",
               rsIf.RSALU_en, rsIf.RSALU_Vj, rsIf.RSALU_Vk, rsIf.RSALU_RoB_index);
    end
    step();
  endtask

  task automatic test_write_snoop();
    setDispatch(OP_ORR, 16, 32'd3, 4, 32'hDEAD, 6);
    rsIf.CDBRS_LSB_en = 1'b1; rsIf.CDBRS_LSB_RoB_index = 4'd4; rsIf.CDBRS_LSB_value = 32'd9;
    step(); idle();
    step();
    testsRun++;
    if ({rsIf.RSALU_en, rsIf.RSALU_Vj, rsIf.RSALU_Vk, rsIf.RSALU_RoB_index} !== {1'b1, 32'd3, 32'd9, 4'd6}) begin
      testsFailed++;
      $display("[TB] FAIL snoop_issue: got en=%b Vj=%h Vk=%h rob=%0d, expected 1/3/9/6",
               rsIf.RSALU_en, rsIf.RSALU_Vj, rsIf.RSALU_Vk, rsIf.RSALU_RoB_index);
    end
    step();
  endtask

  task automatic test_full_order();
    for (int i = 0; i < 8; i++) begin
      setDispatch(OP_ADD, 1, 32'd0, 16, 32'(i), i); #1;
      testsRun++;
      if (rsIf.RSDP_full !== (i == 7)) begin
        testsFailed++; $display("[TB] FAIL full_fill%0d: got %b, expected %b", i, rsIf.RSDP_full, (i == 7));
      end
      step();
    end
    idle();
    rsIf.CDBRS_RS_en = 1'b1; rsIf.CDBRS_RS_RoB_index = 4'd1; rsIf.CDBRS_RS_value = 32'hAA; #1;
    testsRun++;
    if (rsIf.RSDP_full !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_held: got %b, expected 1", rsIf.RSDP_full); end
    step(); idle(); #1;
    testsRun++;
    if ({rsIf.RSALU_en, rsIf.RSDP_full} !== 2'b01) begin
      testsFailed++; $display("[TB] FAIL full_wake: got en=%b full=%b, expected en=0 full=1", rsIf.RSALU_en, rsIf.RSDP_full);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      testsRun++;
      if ({rsIf.RSALU_en, rsIf.RSALU_RoB_index, rsIf.RSALU_Vj, rsIf.RSALU_Vk, rsIf.RSDP_full} !== {1'b1, 4'(k), 32'hAA, 32'(k), 1'b0}) begin
        testsFailed++;
        $display("[TB] FAIL order%0d: got en=%b rob=%0d Vj=%h Vk=%0d full=%b, expected 1/%0d/aa/%0d/0",
                 k, rsIf.RSALU_en, rsIf.RSALU_RoB_index, rsIf.RSALU_Vj, rsIf.RSALU_Vk, rsIf.RSDP_full, k, k);
      end
    end
    step();
    testsRun++;
    if (rsIf.RSALU_en !== 1'b0) begin testsFailed++; $display("[TB] FAIL order_drain: got %b, expected 0", rsIf.RSALU_en); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      setDispatch(OP_XORR, 6, 32'd0, 16, 32'd1, i);
      step();
    end
    setDispatch(OP_ADD, 16, 32'd1, 16, 32'd2, 7);
    rsIf.RoBRS_pre_judge = 1'b0;
    rsIf.CDBRS_RS_en = 1'b1; rsIf.CDBRS_RS_RoB_index = 4'd6; rsIf.CDBRS_RS_value = 32'h77;
    step(); idle(); #1;
    testsRun++;
    if ({rsIf.RSALU_en, rsIf.RSDP_full} !== 2'b00) begin
      testsFailed++; $display("[TB] FAIL flush_now: got en=%b full=%b, expected 0/0", rsIf.RSALU_en, rsIf.RSDP_full);
    end
    rsIf.CDBRS_RS_en = 1'b1; rsIf.CDBRS_RS_RoB_index = 4'd6; rsIf.CDBRS_RS_value = 32'h77;
    for (int c = 0; c < 4; c++) begin
      step();
      testsRun++;
      if (rsIf.RSALU_en !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_after%0d: got %b, expected 0", c, rsIf.RSALU_en); end
    end
    idle();
  endtask

  task automatic test_rdy_stall();
    setDispatch(OP_ADD, 16, 32'd8, 16, 32'd9, 9);
    Sys_rdy = 1'b0;
    step(); idle();
    step();
    testsRun++;
    if (rsIf.RSALU_en !== 1'b0) begin testsFailed++; $display("[TB] FAIL stall_nowrite: got %b, expected 0", rsIf.RSALU_en); end
    setDispatch(OP_SLT, 16, 32'd4, 16, 32'd5, 10);
    step(); idle();
    Sys_rdy = 1'b0;
    step();
    testsRun++;
    if (rsIf.RSALU_en !== 1'b0) begin testsFailed++; $display("[TB] FAIL stall_frozen: got %b, expected 0", rsIf.RSALU_en); end
    Sys_rdy = 1'b1;
    step();
    testsRun++;
    if ({rsIf.RSALU_en, rsIf.RSALU_RoB_index, rsIf.RSALU_Vj} !== {1'b1, 4'd10, 32'd4}) begin
      testsFailed++; $display("[TB] FAIL stall_resume: got en=%b rob=%0d Vj=%0d, expected 1/10/4",
                              rsIf.RSALU_en, rsIf.RSALU_RoB_index, rsIf.RSALU_Vj);
    end
    step();
  endtask

  task automatic test_random();
    int freeCnt;
    int rsIdx;
    logic expFull;
    for (int cyc = 0; cyc < 400; cyc++) begin
      freeCnt = mFreeCount();
      Sys_rdy = ($urandom_range(0, 15) != 0);
      rsIf.RoBRS_pre_judge = ($urandom_range(0, 79) != 0);
      rsIf.DPRS_en = (freeCnt > 0) && ($urandom_range(0, 2) != 0);
      rsIf.DPRS_opcode = 7'($urandom_range(1, 37));
      rsIf.DPRS_pc = $urandom; rsIf.DPRS_imm = $urandom;
      rsIf.DPRS_Vj = $urandom; rsIf.DPRS_Vk = $urandom;
      rsIf.DPRS_Qj = ($urandom_range(0, 1) != 0) ? 5'd16 : 5'($urandom_range(0, 7));
      rsIf.DPRS_Qk = ($urandom_range(0, 1) != 0) ? 5'd16 : 5'($urandom_range(0, 7));
      rsIf.DPRS_RoB_index = 4'($urandom_range(0, 15));
      rsIdx = $urandom_range(0, 7);
      rsIf.CDBRS_RS_en = ($urandom_range(0, 1) != 0);
      rsIf.CDBRS_RS_RoB_index = 4'(rsIdx); rsIf.CDBRS_RS_value = $urandom;
      rsIf.CDBRS_LSB_en = ($urandom_range(0, 1) != 0);
      rsIf.CDBRS_LSB_RoB_index = 4'((rsIdx + $urandom_range(1, 7)) % 8); rsIf.CDBRS_LSB_value = $urandom;
      #1;
      expFull = (freeCnt == 0) || (freeCnt == 1 && rsIf.DPRS_en);
      testsRun++;
      if (rsIf.RSDP_full !== expFull) begin
        testsFailed++; $display("[TB] FAIL rand_full cyc %0d: got %b, expected %b", cyc, rsIf.RSDP_full, expFull);
      end
      step();
      testsRun++;
      if ({rsIf.RSALU_en, rsIf.RSALU_opcode, rsIf.RSALU_pc, rsIf.RSALU_Vj, rsIf.RSALU_Vk, rsIf.RSALU_imm, rsIf.RSALU_RoB_index}
          !== {eEn, eOpcode, ePc, eVj, eVk, eImm, eRob}) begin
        testsFailed++;
        $display("[TB] FAIL rand_issue cyc %0d: got en=%b op=%0d pc=%h Vj=%h Vk=%h imm=%h rob=%0d, expected en=%b op=%0d pc=%h Vj=%h Vk=%h imm=%h rob=%0d",
                 cyc, rsIf.RSALU_en, rsIf.RSALU_opcode, rsIf.RSALU_pc, rsIf.RSALU_Vj, rsIf.RSALU_Vk, rsIf.RSALU_imm,
                 rsIf.RSALU_RoB_index, eEn, eOpcode, ePc, eVj, eVk, eImm, eRob);
      end
    end
    idle();
  endtask

  initial begin
    modelClear();
    idle();
    test_reset();
    test_ready_dispatch();
    test_cdb_wakeup();
    test_write_snoop();
    test_full_order();
    test_flush();
    test_rdy_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
